estagio_decodificacao: RTL and testbench
========================================

// Module: estagio_decodificacao
// PURPOSE
//  Decode/issue stage directly upstream of banco_registradores. Latches one 16-bit instruction, decodes
//  opcode and register fields, and drives entrada1/2/3 to the register file. Holds issue on RAW/WAW hazards
//  via a 16-bit busy scoreboard, which writeback clears. Valid/ready on both sides; one instruction in flight here.
// PARAMETERS
//  NUM_REGS     16  architectural registers; one scoreboard bit each
//  ADDR_W       4   register address width
//  INSTR_W      16  instruction width
//  STALL_CNT_W  16  stall counter width; counter saturates
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-low; clears all state
//  instr_valid  in   1        fetch offers instr
//  instr_ready  out  1        stage accepts instr this cycle
//  instr        in   16       [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt; LI uses [7:0] as imm8
//  out_valid    out  1        decoded instruction and regfile read data valid
//  out_ready    in   1        execute accepts
//  op           out  4        opcode of issued instruction
//  imm8         out  8        instr[7:0] of issued instruction
//  entrada1     out  4        rs address to register file
//  entrada2     out  4        rt address to register file
//  entrada3     out  4        rd address to register file
//  illegal      out  1        issued opcode is 0xC-0xE; executes as NOP
//  wb_valid     in   1        writeback retires a write
//  wb_addr      in   4        register retired; clears busy[wb_addr]
//  busy         out  16       scoreboard state, for debug
//  stall_count  out  16       cycles spent in CHECK with a hazard
// BEHAVIOUR
//  Reset: state=EMPTY, IR=0, busy=0, stall_count=0, out_valid=0, instr_ready=1.
//   Reset mid-operation drops the held instruction silently.
//  Read/write classes (package table):
//   - ALU 0x0-0x6: read rs, rt; write rd.
//   - LI 0x7: write rd.
//   - LW 0x8: read rs; write rd.
//   - SW 0x9: read rs, rt.
//   - BEQ 0xA: read rs, rt.
//   - JMP 0xB, NOP 0xF, illegal 0xC-0xE: no reads, no writes.
//  hazard = (rd_rs & busy[rs]) | (rd_rt & busy[rt]) | (wr_rd & busy[rd]).
//  FSM:
//   - EMPTY: instr_ready=1; instr_valid captures instr into IR -> CHECK.
//   - CHECK: instr_ready=0, out_valid=0. Hazard -> stay; stall_count+1, saturating at all-ones.
//     No hazard -> ISSUE; set busy[rd] on this edge if wr_rd.
//   - ISSUE: out_valid=1. The regfile sampled IR addresses on the CHECK->ISSUE edge, so saida1..3 are valid.
//     instr_ready=out_ready. out_ready & instr_valid -> capture -> CHECK.
//     out_ready & !instr_valid -> EMPTY. !out_ready -> hold all outputs stable.
//  entrada1/2/3, op, imm8 and illegal come from IR continuously; IR changes only on capture.
//  Scoreboard: wb_valid clears busy[wb_addr] at the edge. If a set and a clear hit the same bit
//   on the same edge, the set wins. wb_valid for a non-busy register is ignored.
//  Minimum throughput: 1 instruction per 2 cycles (CHECK+ISSUE); no hazard ever resolves without wb_valid.
// CONFIGURATION
//  WB_BYPASS_EN defined: hazard uses busy & ~onehot(wb_addr) when wb_valid, so a retiring register
//   unblocks CHECK on the same cycle.
//  Not defined: hazard uses registered busy only, adding one stall cycle after the retiring writeback.
// STRUCTURE
//  Package decod_pkg: opcode localparams OP_ADD..OP_NOP; read/write class function (rd_rs, rd_rt, wr_rd);
//   state encodings EMPTY/CHECK/ISSUE.
//  Sub-module placar (scoreboard): busy register, set/clear/priority logic, hazard output, bypass under
//   WB_BYPASS_EN. FSM and IR stay in the top.
// TESTING
//  1. Release reset; send ADD 0x0123 (rd=1, rs=2, rt=3), out_ready=1 -> out_valid 2 cycles after accept;
//     entrada1=2, entrada2=3, entrada3=1; busy=0x0002.
//  2. ADD r1 issued, then SUB 0x1415 (reads r1) -> held in CHECK, stall_count increments each cycle.
//     Send wb_valid/wb_addr=1 -> SUB issues next cycle (bypass) or one cycle later (no bypass); busy bit 1 cleared.
//  3. LI 0x75AB while busy[5]=1 -> WAW stall. After wb of r5: issue with imm8=0xAB, busy[5]=1 again.
//  4. ISSUE with out_ready=0 for 5 cycles -> op, entrada*, out_valid stable; instr_ready=0.
//  5. Opcode 0xD -> illegal=1, no busy change, no stall even when all busy=0xFFFF.
//  6. Drive reset low in CHECK with busy=0x00F0 -> immediately out_valid=0, busy=0, stall_count=0, state EMPTY.
//  Also check: set/clear collision on the same edge (set wins); stall_count saturation at 0xFFFF.

Source files
------------

// File: rtl/decod_pkg.sv
// Shared definitions for the decode/issue stage: opcodes, FSM states and the
// per-opcode register read/write class table.
package decod_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_LI  = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2
  } state_t;

  typedef struct packed {
    logic rd_rs;
    logic rd_rt;
    logic wr_rd;
  } rw_class_t;

  function automatic rw_class_t rw_class(input logic [3:0] op);
    rw_class_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        c.rd_rs = 1'b1;
        c.rd_rt = 1'b1;
        c.wr_rd = 1'b1;
      end
      OP_LI: c.wr_rd = 1'b1;
      OP_LW: begin
        c.rd_rs = 1'b1;
        c.wr_rd = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        c.rd_rs = 1'b1;
        c.rd_rt = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/estagio_decodificacao_placar.sv
// Busy scoreboard: one bit per register, set on issue, cleared by writeback.
// Define WB_BYPASS_EN to let a same-cycle writeback unblock the hazard check.
module placar
  import decod_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic [ADDR_W-1:0]   rs,
  input  logic [ADDR_W-1:0]   rt,
  input  logic [ADDR_W-1:0]   rd,
  input  rw_class_t           cls,
  output logic [NUM_REGS-1:0] busy,
  output logic                hazard
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_eff;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign busy_eff = busy & ~clr_mask;
`else
  assign busy_eff = busy;
`endif

  assign hazard = (cls.rd_rs & busy_eff[rs]) |
                  (cls.rd_rt & busy_eff[rt]) |
                  (cls.wr_rd & busy_eff[rd]);

  // Set is OR-ed in after the clear so an issue beats a same-edge writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/estagio_decodificacao.sv
// Decode/issue stage: holds one instruction, waits out RAW/WAW hazards on the
// busy scoreboard, then presents register addresses to banco_registradores.
// Optional macro WB_BYPASS_EN (see placar).
module estagio_decodificacao
  import decod_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 4,
  parameter int INSTR_W     = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [INSTR_W-1:0]     instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             op,
  output logic [7:0]             imm8,
  output logic [ADDR_W-1:0]      entrada1,
  output logic [ADDR_W-1:0]      entrada2,
  output logic [ADDR_W-1:0]      entrada3,
  output logic                   illegal,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  output logic [NUM_REGS-1:0]    busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               capture;
  logic               set_en;
  logic               hazard;
  rw_class_t          cls;

  assign op       = ir[15:12];
  assign entrada3 = ir[11:8];
  assign entrada1 = ir[7:4];
  assign entrada2 = ir[3:0];
  assign imm8     = ir[7:0];
  assign illegal  = is_illegal(op);
  assign cls      = rw_class(op);

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    out_valid   = 1'b0;
    capture     = 1'b0;
    set_en      = 1'b0;
    case (state)
      EMPTY: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          capture   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!hazard) begin
          set_en    = cls.wr_rd;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        out_valid   = 1'b1;
        instr_ready = out_ready;
        if (out_ready) begin
          capture   = instr_valid;
          state_nxt = instr_valid ? CHECK : EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) ir <= instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if ((state == CHECK) && hazard && (stall_count != {STALL_CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

  placar #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_placar (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (entrada3),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .rs       (entrada1),
    .rt       (entrada2),
    .rd       (entrada3),
    .cls      (cls),
    .busy     (busy),
    .hazard   (hazard)
  );

endmodule

// File: tb/tb_estagio_decodificacao.sv
// Directed bench for estagio_decodificacao; expectations follow WB_BYPASS_EN.
module tb_estagio_decodificacao;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [7:0]  imm8;
  logic [3:0]  entrada1;
  logic [3:0]  entrada2;
  logic [3:0]  entrada3;
  logic        illegal;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] busy;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall;

  estagio_decodificacao dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op          (op),
    .imm8        (imm8),
    .entrada1    (entrada1),
    .entrada2    (entrada2),
    .entrada3    (entrada3),
    .illegal     (illegal),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .busy        (busy),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    out_ready   = 1'b1;
    wb_valid    = 1'b0;
    wb_addr     = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issues one instruction from EMPTY with out_ready=1; returns to EMPTY.
  task automatic issue_one(input logic [15:0] w, output bit ok);
    int n;
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_instr_ready: got %b exp 1", instr_ready); end
    checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL rst_busy: got %h exp 0000", busy); end
    checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL rst_stall: got %h exp 0000", stall_count); end
    checks++; if ({op, entrada3, entrada1, entrada2} !== 16'h0000) begin errors++; $display("FAIL rst_ir: got %h exp 0000", {op, entrada3, entrada1, entrada2}); end
  endtask

  task automatic test_basic_issue();
    instr       = 16'h0123;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_check_out_valid: got %b exp 0", out_valid); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL t1_check_instr_ready: got %b exp 0", instr_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_out_valid: got %b exp 1", out_valid); end
    checks++; if ({entrada1, entrada2, entrada3} !== 12'h231) begin errors++; $display("FAIL t1_entradas: got %h exp 231", {entrada1, entrada2, entrada3}); end
    checks++; if (op !== 4'h0) begin errors++; $display("FAIL t1_op: got %h exp 0", op); end
    checks++; if (busy !== 16'h0002) begin errors++; $display("FAIL t1_busy: got %h exp 0002", busy); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL t1_illegal: got %b exp 0", illegal); end
    @(negedge clk);
    checks++; if ({instr_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL t1_back_empty: got %b exp 10", {instr_ready, out_valid}); end
  endtask

  task automatic test_raw_stall();
    instr       = 16'h1415;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL t2_stall0: got %0d exp 0", stall_count); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (stall_count !== 16'(i)) begin errors++; $display("FAIL t2_stall_inc: got %0d exp %0d", stall_count, i); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_held: got %b exp 0", out_valid); end
    end
    wb_valid = 1'b1;
    wb_addr  = 4'h1;
    @(negedge clk);
    wb_valid = 1'b0;
`ifdef WB_BYPASS_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd4;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_nobypass_wait: got %b exp 0", out_valid); end
    checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL t2_cleared: got %h exp 0000", busy); end
    @(negedge clk);
`endif
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_issue: got %b exp 1", out_valid); end
    checks++; if (busy !== 16'h0010) begin errors++; $display("FAIL t2_busy: got %h exp 0010", busy); end
    checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL t2_stall_final: got %0d exp %0d", stall_count, exp_stall); end
    checks++; if ({op, entrada1, entrada2, entrada3} !== 16'h1154) begin errors++; $display("FAIL t2_fields: got %h exp 1154", {op, entrada1, entrada2, entrada3}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_waw();
    instr       = 16'h7500;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 16'h75AB;
    @(negedge clk);
    checks++; if ({out_valid, instr_ready} !== 2'b11) begin errors++; $display("FAIL t3_issue_ready: got %b exp 11", {out_valid, instr_ready}); end
    checks++; if (busy !== 16'h0030) begin errors++; $display("FAIL t3_busy_set: got %h exp 0030", busy); end
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if (imm8 !== 8'hAB) begin errors++; $display("FAIL t3_captured: got %h exp AB", imm8); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_check: got %b exp 0", out_valid); end
    repeat (2) @(negedge clk);
    exp_stall = exp_stall + 16'd2;
    checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL t3_waw_stall: got %0d exp %0d", stall_count, exp_stall); end
    wb_valid = 1'b1;
    wb_addr  = 4'h5;
    @(negedge clk);
    wb_valid = 1'b0;
`ifndef WB_BYPASS_EN
    exp_stall = exp_stall + 16'd1;
    checks++; if (busy !== 16'h0010) begin errors++; $display("FAIL t3_cleared: got %h exp 0010", busy); end
    @(negedge clk);
`endif
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_issue: got %b exp 1", out_valid); end
    checks++; if ({op, imm8} !== 12'h7AB) begin errors++; $display("FAIL t3_li_fields: got %h exp 7AB", {op, imm8}); end
    checks++; if (busy !== 16'h0030) begin errors++; $display("FAIL t3_busy_again: got %h exp 0030", busy); end
    checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL t3_stall_final: got %0d exp %0d", stall_count, exp_stall); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    out_ready   = 1'b0;
    instr       = 16'h9AB3;
    instr_valid = 1'b1;
    @(negedge clk);
    instr       = 16'hF000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_valid, instr_ready} !== 2'b10) begin errors++; $display("FAIL t4_hs_cycle%0d: got %b exp 10", i, {out_valid, instr_ready}); end
      checks++; if ({op, entrada1, entrada2, entrada3} !== 16'h9B3A) begin errors++; $display("FAIL t4_stable_cycle%0d: got %h exp 9B3A", i, {op, entrada1, entrada2, entrada3}); end
      @(negedge clk);
    end
    checks++; if (busy !== 16'h0030) begin errors++; $display("FAIL t4_sw_no_write: got %h exp 0030", busy); end
    out_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if ({op, out_valid} !== 5'b1111_0) begin errors++; $display("FAIL t4_next_captured: got %b exp 11110", {op, out_valid}); end
    repeat (2) @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL t4_empty: got %b exp 1", instr_ready); end
  endtask

  task automatic test_collision();
    instr       = 16'h7900;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    wb_valid    = 1'b1;
    wb_addr     = 4'h9;
    @(negedge clk);
    wb_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tc_issue: got %b exp 1", out_valid); end
    checks++; if (busy !== 16'h0230) begin errors++; $display("FAIL tc_set_wins: got %h exp 0230", busy); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bit ok;
    do_reset();
    for (int r = 0; r < 16; r++) begin
      issue_one(16'h7000 | 16'(r << 8), ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t5_fill_r%0d: got %b exp 1", r, ok); end
    end
    checks++; if (busy !== 16'hFFFF) begin errors++; $display("FAIL t5_all_busy: got %h exp FFFF", busy); end
    instr       = 16'hD123;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checks++; if ({out_valid, illegal} !== 2'b11) begin errors++; $display("FAIL t5_illegal_issue: got %b exp 11", {out_valid, illegal}); end
    checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL t5_no_stall: got %h exp 0000", stall_count); end
    checks++; if (busy !== 16'hFFFF) begin errors++; $display("FAIL t5_busy_same: got %h exp FFFF", busy); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_check();
    bit ok;
    do_reset();
    for (int r = 4; r < 8; r++) begin
      issue_one(16'h7000 | 16'(r << 8), ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t6_fill_r%0d: got %b exp 1", r, ok); end
    end
    checks++; if (busy !== 16'h00F0) begin errors++; $display("FAIL t6_busy_pre: got %h exp 00F0", busy); end
    instr       = 16'h0145;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL t6_stalling: got %0d exp 1", stall_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({out_valid, instr_ready} !== 2'b01) begin errors++; $display("FAIL t6_async_hs: got %b exp 01", {out_valid, instr_ready}); end
    checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL t6_async_busy: got %h exp 0000", busy); end
    checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL t6_async_stall: got %h exp 0000", stall_count); end
    checks++; if (entrada1 !== 4'h0) begin errors++; $display("FAIL t6_ir_cleared: got %h exp 0", entrada1); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({instr_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL t6_after_release: got %b exp 10", {instr_ready, out_valid}); end
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    issue_one(16'h7300, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ts_li: got %b exp 1", ok); end
    instr       = 16'h0034;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (65534) @(negedge clk);
    checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL ts_near: got %h exp FFFE", stall_count); end
    @(negedge clk);
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL ts_max: got %h exp FFFF", stall_count); end
    repeat (5) @(negedge clk);
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL ts_saturate: got %h exp FFFF", stall_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ts_still_held: got %b exp 0", out_valid); end
    do_reset();
  endtask

  initial begin
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    out_ready   = 1'b1;
    wb_valid    = 1'b0;
    wb_addr     = 4'h0;
    exp_stall   = 16'h0000;
    test_reset();
    test_basic_issue();
    test_raw_stall();
    test_back_to_back_waw();
    test_hold();
    test_collision();
    test_illegal();
    test_reset_in_check();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
